// File: rtl/perm_key_controller.sv
// perm_key_controller: validates a shadow 8x3-bit permutation, drains the pipe, then atomically swaps
// the active key and its inverse. Rev 1.0
`default_nettype none

module perm_key_controller #(
  parameter int PIPE_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_idx,
  input  logic [2:0]  cfg_val,
  input  logic        cfg_commit,
  output logic        cfg_ready,
  output logic        commit_done,
  output logic        commit_err,
  output logic        key_loaded,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        pipe_en,
  output logic [23:0] act_perm,
  output logic [23:0] inv_perm
);

  localparam logic [23:0] C_IDENT = 24'hFAC688;
  localparam logic [3:0]  C_DEPTH = 4'(PIPE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DRAIN = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_shadow [8];
  logic [2:0]  r_k;
  logic [7:0]  r_seen;
  logic [3:0]  r_cnt;
  logic [23:0] r_act, r_inv;
  logic        r_done, r_err, r_loaded;
  logic [23:0] w_shadow_flat, w_inv;
  logic [2:0]  w_cur;
  logic        w_dup;

  assign w_cur = r_shadow[r_k];
  assign w_dup = r_seen[w_cur];

  // Inverse is only ever latched after the bijection check succeeds, so no collisions here.
  always_comb begin
    w_shadow_flat = '0;
    w_inv         = '0;
    for (int i = 0; i < 8; i++) begin
      w_shadow_flat[3*i +: 3]             = r_shadow[i];
      w_inv[3*int'(r_shadow[i]) +: 3]     = 3'(i);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (cfg_commit) w_next = S_CHECK;
      S_CHECK: begin
        if (w_dup)            w_next = S_IDLE;
        else if (r_k == 3'd7) w_next = S_DRAIN;
      end
      S_DRAIN: if (r_cnt == 4'd1) w_next = S_SWAP;
      S_SWAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_shadow[i] <= C_IDENT[3*i +: 3];
      r_k      <= '0;
      r_seen   <= '0;
      r_cnt    <= '0;
      r_act    <= C_IDENT;
      r_inv    <= C_IDENT;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_done <= (r_state == S_SWAP);
      r_err  <= (r_state == S_CHECK) && w_dup;
      if ((r_state == S_IDLE) && cfg_wr) r_shadow[cfg_idx] <= cfg_val;
      unique case (r_state)
        S_IDLE: begin
          r_k    <= '0;
          r_seen <= '0;
        end
        S_CHECK: begin
          r_k    <= r_k + 3'd1;
          r_seen <= r_seen | (8'd1 << w_cur);
          if ((r_k == 3'd7) && !w_dup) r_cnt <= C_DEPTH;
        end
        S_DRAIN: r_cnt <= r_cnt - 4'd1;
        S_SWAP: begin
          r_act    <= w_shadow_flat;
          r_inv    <= w_inv;
          r_loaded <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready   = (r_state == S_IDLE);
  assign in_ready    = (r_state == S_IDLE) || (r_state == S_CHECK);
  assign pipe_en     = in_valid & in_ready;
  assign commit_done = r_done;
  assign commit_err  = r_err;
  assign key_loaded  = r_loaded;
  assign act_perm    = r_act;
  assign inv_perm    = r_inv;

endmodule

`default_nettype wire

// File: tb/tb_perm_key_controller.sv
// tb_perm_key_controller: directed commits; expected pulses queued at issue time and checked by a
// separate monitor on each commit_done/commit_err.
`default_nettype none

module tb_perm_key_controller;

  localparam int D = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0, cfg_commit = 1'b0, in_valid = 1'b0;
  logic [2:0]  cfg_idx = '0, cfg_val = '0;
  logic        cfg_ready, commit_done, commit_err, key_loaded, in_ready, pipe_en;
  logic [23:0] act_perm, inv_perm;

  perm_key_controller #(.PIPE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_val(cfg_val),
    .cfg_commit(cfg_commit), .cfg_ready(cfg_ready), .commit_done(commit_done),
    .commit_err(commit_err), .key_loaded(key_loaded), .in_valid(in_valid),
    .in_ready(in_ready), .pipe_en(pipe_en), .act_perm(act_perm), .inv_perm(inv_perm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [23:0] act;
    logic [23:0] inv;
    bit          loaded;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (commit_done || commit_err)) begin
      chk("done_err_exclusive", 32'(commit_done & commit_err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({commit_done, commit_err}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", 32'({commit_done, commit_err}), e.err ? 32'd1 : 32'd2);
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("act_perm", 32'(act_perm), 32'(e.act));
        chk("inv_perm", 32'(inv_perm), 32'(e.inv));
        chk("key_loaded", 32'(key_loaded), 32'(e.loaded));
        chk("cfg_ready_after", 32'(cfg_ready), 32'd1);
      end
    end
  end

  task automatic write_perm(input logic [23:0] p);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_wr = 1'b1; cfg_idx = 3'(i); cfg_val = p[3*i +: 3];
    end
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic write_one(input logic [2:0] idx, input logic [2:0] val);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_idx = idx; cfg_val = val;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
  task automatic commit(input bit err, input logic [23:0] act, input logic [23:0] inv,
                        input bit loaded, input int lat, input bit expect_pulse, output int t);
    t = cyc;
    if (expect_pulse) sb.push_back('{err, act, inv, loaded, cyc + lat});
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("outstanding_expectations", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_act", 32'(act_perm), 32'hFAC688);
    chk("rst_inv", 32'(inv_perm), 32'hFAC688);
    chk("rst_loaded", 32'(key_loaded), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Duplicate destination 1 at index 3: error pulse at T+5, no stall.
    in_valid = 1'b1;
    write_one(3'd3, 3'd1);
    commit(1'b1, 24'hFAC688, 24'hFAC688, 1'b0, 5, 1'b1, t);
    while (cyc <= t + 7) begin
      chk("err_no_stall", 32'(in_ready), 32'd1);
      chk("err_pipe_en", 32'(pipe_en), 32'd1);
      @(negedge clk);
    end
    wait_sb();

    // Reversal permutation is self-inverse.
    write_perm(24'h053977);
    commit(1'b0, 24'h053977, 24'h053977, 1'b1, 10 + D, 1'b1, t);
    wait_sb();

    // Rotation with continuous traffic: stall exactly at T+9..T+10.
    write_perm(24'h1F58D1);
    commit(1'b0, 24'h1F58D1, 24'hD63447, 1'b1, 10 + D, 1'b1, t);
    while (cyc <= t + 12) begin
      chk("stall_in_ready", 32'(in_ready), (cyc == t + 9 || cyc == t + 10) ? 32'd0 : 32'd1);
      chk("stall_pipe_en", 32'(pipe_en), (cyc == t + 9 || cyc == t + 10) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    wait_sb();

    // Write during CHECK and commit during DRAIN are both dropped.
    commit(1'b0, 24'h1F58D1, 24'hD63447, 1'b1, 10 + D, 1'b1, t);
    @(negedge clk);
    @(negedge clk);
    chk("busy_cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_wr = 1'b1; cfg_idx = 3'd0; cfg_val = 3'd5;
    @(negedge clk);
    cfg_wr = 1'b0;
    while (cyc < t + 9) @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    wait_sb();
    repeat (20) @(negedge clk);

    // Reset in the middle of CHECK: identity restored, no pulse.
    write_perm(24'h053977);
    commit(1'b0, 24'h0, 24'h0, 1'b0, 0, 1'b0, t);
    while (cyc < t + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_act", 32'(act_perm), 32'hFAC688);
    chk("mid_rst_inv", 32'(inv_perm), 32'hFAC688);
    chk("mid_rst_loaded", 32'(key_loaded), 32'd0);
    chk("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Shadow was reset to identity as well.
    commit(1'b0, 24'hFAC688, 24'hFAC688, 1'b1, 10 + D, 1'b1, t);
    wait_sb();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/perm_key_controller.md
# perm_key_controller

Sequences key (permutation) updates for the bit-permutation pipes. Software loads a new 8-entry, 3-bit permutation into a shadow bank and issues a commit. The controller checks that the shadow is a true bijection, stalls and drains the data pipe, then atomically swaps the active key. It drives the active permutation to the encrypt pipe and the computed inverse to the decrypt pipe, and gates the pipe enable so that no byte is permuted with a half-updated key.

## Interface
Parameters:
- PIPE_DEPTH, 1: register stages between the pipe `en` input and its `valid_out`; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_wr  in  1  write shadow entry `cfg_idx` with `cfg_val`; honoured only when cfg_ready=1.
- cfg_idx  in  3  shadow entry index.
- cfg_val  in  3  destination bit position for source bit `cfg_idx`.
- cfg_commit  in  1  request validate-and-swap; honoured only when cfg_ready=1.
- cfg_ready  out  1  1 only in state IDLE.
- commit_done  out  1  one-cycle pulse: new key is active.
- commit_err  out  1  one-cycle pulse: shadow rejected (duplicate destination); active key unchanged.
- key_loaded  out  1  1 once any commit has succeeded since reset.
- in_valid  in  1  upstream byte available.
- in_ready  out  1  controller accepts a byte this cycle.
- pipe_en  out  1  `en` to the permutation pipe; equals in_valid & in_ready.
- act_perm  out  24  active key; bits [3i+2:3i] = perm_i.
- inv_perm  out  24  inverse of act_perm; inv[act_i] = i.

## Operation
- Reset: state IDLE. Shadow, act_perm and inv_perm are identity (24'hFAC688). key_loaded=0, commit_done=0, commit_err=0, cfg_ready=1, in_ready=1.
- States: IDLE → CHECK → DRAIN → SWAP → IDLE; CHECK → IDLE on error.
- IDLE: cfg_wr updates the shadow at the clock edge. cfg_commit moves the FSM to CHECK. If cfg_wr and cfg_commit are both high in one cycle, the write lands first and CHECK sees the written value.
- CHECK: 8 cycles, index k = 0..7, with an 8-bit `seen` bitmap cleared on entry.
  - Cycle k: if seen[shadow_k]=1, go to IDLE and pulse commit_err on the next cycle.
  - Otherwise set seen[shadow_k]. After k=7 with no error, go to DRAIN.
- DRAIN: in_ready=0. A down-counter loaded with PIPE_DEPTH decrements each cycle; at 1 the FSM moves to SWAP.
- SWAP: in_ready=0. At the edge, act_perm ← shadow and inv_perm ← inverse(shadow), both updated in the same edge. The FSM returns to IDLE with commit_done=1 and key_loaded=1 for that first IDLE cycle.
- in_ready=1 in IDLE and CHECK, 0 in DRAIN and SWAP. Traffic flows during CHECK because the active key has not changed yet.
- cfg_wr and cfg_commit outside IDLE are ignored, with no queuing. The shadow is retained after a commit error or a success.
- rst at any point returns to the reset state, including identity keys and loss of a partial check.

## Timing
- Commit sampled in cycle T (IDLE).
  - CHECK occupies T+1..T+8.
  - DRAIN occupies T+9..T+8+PIPE_DEPTH.
  - SWAP is T+9+PIPE_DEPTH.
  - New act_perm, inv_perm, commit_done and in_ready=1 appear in cycle T+10+PIPE_DEPTH.
- Duplicate found at index k (cycle T+1+k): commit_err=1 and cfg_ready=1 in cycle T+2+k.
- Stall window: exactly PIPE_DEPTH+1 consecutive cycles of in_ready=0 per successful commit; none on error.
- pipe_en is combinational from in_valid and state; no added latency.
- commit_done and commit_err are registered, single-cycle, and never high together.

## Test plan
- Reset, then idle 5 cycles → act_perm=24'hFAC688, inv_perm=24'hFAC688, key_loaded=0, cfg_ready=1.
- Write perm_i=7−i for i=0..7, commit at T with PIPE_DEPTH=1 → commit_done at T+11, act_perm=inv_perm=24'h053977, key_loaded=1.
- From identity, write idx 3 ← 1, commit at T → commit_err at T+5, act_perm remains 24'hFAC688, no in_ready drop.
- Hold in_valid=1 continuously across a successful commit (PIPE_DEPTH=1) → in_ready=0 for exactly cycles T+9..T+10; pipe_en high in every other cycle.
- Issue cfg_wr to idx 0 during CHECK, then a second cfg_commit during DRAIN → both ignored; shadow entry 0 unchanged; one commit_done only.
- Assert rst for 1 cycle at T+5 of a commit → identity keys, state IDLE, no commit_done or commit_err pulse.
